// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//   Prioritised, nesting-capable interrupt controller. Request edges on the
//   button lines are captured as pending, one request at a time is presented
//   to the CPU with its id and entry vector, and an in-service register makes
//   sure only strictly higher priorities can preempt a running handler.
//
//   Optional feature macro: DEBOUNCE_EN
//     defined   : per-line debounce counter (DEB_CYCLES stable cycles) after
//                 the synchroniser
//     undefined : the edge register samples the synchronised level directly
//
// Ports
//   clk        in   1      CPU clock
//   rst        in   1      asynchronous reset, active-low
//   irq_in     in   N_SRC  raw request lines, asynchronous to clk
//   ie         in   1      global interrupt enable
//   int_ack    in   1      CPU accepts the presented interrupt (1-cycle pulse)
//   int_ret    in   1      CPU return-from-interrupt (1-cycle pulse)
//   int_req    out  1      request to the CPU
//   int_id     out  ID_W   id of the presented source
//   int_vec    out  VEC_W  entry vector of the presented source
//   irw        out  N_SRC  pending bits (LEDs)
//   in_service out  N_SRC  in-service register
// -----------------------------------------------------------------------------
module interrupt_controller #(
   parameter int                N_SRC      = 3,
   parameter int                ID_W       = 2,
   parameter int                VEC_W      = 32,
   parameter logic [VEC_W-1:0]  VEC_BASE   = 32'h0000_1000,
   parameter logic [VEC_W-1:0]  VEC_STRIDE = 32'h0000_0100,
   parameter int                DEB_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SRC-1:0]  irq_in,
   input  logic              ie,
   input  logic              int_ack,
   input  logic              int_ret,
   output logic              int_req,
   output logic [ID_W-1:0]   int_id,
   output logic [VEC_W-1:0]  int_vec,
   output logic [N_SRC-1:0]  irw,
   output logic [N_SRC-1:0]  in_service
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [N_SRC-1:0]  irq_p0, irq_p1;
   logic [N_SRC-1:0]  lvl;
   logic [N_SRC-1:0]  lvl_d_p2;
   logic [N_SRC-1:0]  rise_p3;
   logic [N_SRC-1:0]  pending;
   logic [N_SRC-1:0]  eligible;
   logic [N_SRC-1:0]  ack_set;
   logic [N_SRC-1:0]  ret_clr;
   logic [ID_W-1:0]   cand;
   logic              any_elig;

   // One-hot of the highest set bit of v (zero if v is zero).
   function automatic logic [N_SRC-1:0] top_bit(input logic [N_SRC-1:0] v);
      logic [N_SRC-1:0] r;
      r = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   // Bit i set when no bit of v at index >= i is set, i.e. i is strictly
   // above the highest in-service level (all ones when nothing is in service).
   function automatic logic [N_SRC-1:0] above_mask(input logic [N_SRC-1:0] v);
      logic [N_SRC-1:0] m;
      for (int i = 0; i < N_SRC; i++) begin
         m[i] = ((v >> i) == '0);
      end
      return m;
   endfunction

   function automatic logic [N_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
      logic [N_SRC-1:0] r;
      for (int i = 0; i < N_SRC; i++) begin
         r[i] = (id == ID_W'(i));
      end
      return r;
   endfunction

   // ---- stage p0/p1: two-flop synchroniser ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_p0 <= '0;
         irq_p1 <= '0;
      end else begin
         irq_p0 <= irq_in;
         irq_p1 <= irq_p0;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);

   logic [CNT_W-1:0]  deb_cnt [N_SRC];
   logic [N_SRC-1:0]  deb_lvl;

   // The counter only runs while the synchronised line disagrees with the
   // debounced level; any agreement (a bounce back) restarts it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_lvl <= '0;
         for (int i = 0; i < N_SRC; i++) deb_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_SRC; i++) begin
            if (irq_p1[i] == deb_lvl[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
               deb_lvl[i] <= irq_p1[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign lvl = deb_lvl;
`else
   assign lvl = irq_p1;
`endif

   // ---- stage p2/p3: edge register and registered rising-edge pulse ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lvl_d_p2 <= '0;
         rise_p3  <= '0;
      end else begin
         lvl_d_p2 <= lvl;
         rise_p3  <= lvl & ~lvl_d_p2;
      end
   end

   // ---- arbitration ----
   assign eligible = pending & above_mask(in_service);
   assign any_elig = |eligible;

   always_comb begin
      cand = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (eligible[i]) cand = ID_W'(i);
      end
   end

   assign ack_set = (state == REQ && int_ack) ? id_onehot(int_id) : '0;
   assign ret_clr = int_ret ? top_bit(in_service) : '0;

   // Set is OR-ed in after the clear, so a new edge wins over an ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending    <= '0;
         in_service <= '0;
      end else begin
         pending    <= (pending & ~ack_set) | rise_p3;
         in_service <= (in_service & ~ret_clr) | ack_set;
      end
   end

   assign irw = pending;

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ie && any_elig) state_nxt = REQ;
         REQ:     if (int_ack)        state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      int_req = 1'b0;
      if (state == REQ) int_req = 1'b1;
   end

   // id and vector are latched on entry to REQ and stay frozen until the ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_id  <= '0;
         int_vec <= VEC_BASE;
      end else if (state == IDLE && state_nxt == REQ) begin
         int_id  <= cand;
         int_vec <= VEC_BASE + VEC_W'(cand) * VEC_STRIDE;
      end
   end

endmodule
